axil_err_responder: RTL and testbench

- Terminating AXI-Lite slave that completes every transaction routed to it with a fixed error response, without touching any register or downstream path.
- Sits behind the register station as the sink for requests flagged by the request-side protocol checks (misaligned address, zero WSTRB) or for unmapped address space.
- Keeps the master's handshakes legal: AW and W are accepted in either order, exactly one B is returned per AW/W pair, and exactly one R per AR.
- Optionally counts completed error writes and reads for debug visibility.

---
 rtl/axil_err_responder.sv | 147 ++++++++++++++
 tb/tb_axil_err_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_err_responder.sv
// Terminating AXI-Lite slave: answers every write and read with a fixed error response.
// Define AXIL_ERR_RESP_CNT_EN to build the saturating completed-error counters.
//
// write state | meaning
// ------------+------------------------------------------------
// IDLE        | nothing held, AW and W both accepted
// HAVE_AW     | address taken, waiting for write data
// HAVE_W      | write data taken, waiting for address
// RESP        | pair complete, B presented until bready
module axil_err_responder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [1:0]            RESP       = 2'b10,
  parameter logic [DATA_WIDTH-1:0] RDATA_FILL = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [CNT_WIDTH-1:0]    wr_err_cnt_o,
  output logic [CNT_WIDTH-1:0]    rd_err_cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HAVE_AW = 2'd1,
    HAVE_W  = 2'd2,
    RESP_ST = 2'd3
  } wr_state_t;

  wr_state_t wr_state, wr_state_nxt;
  logic      aw_held, w_held;
  logic      aw_hs, w_hs, b_hs;
  logic      rvalid_q;
  logic      ar_hs, r_hs;
  logic      unused_inputs;

  // Address, protection and data are never inspected; the response is fixed.
  assign unused_inputs = ^{s_axi_awaddr, s_axi_awprot, s_axi_wdata, s_axi_wstrb,
                           s_axi_araddr, s_axi_arprot};

  assign aw_held = (wr_state == HAVE_AW) || (wr_state == RESP_ST);
  assign w_held  = (wr_state == HAVE_W)  || (wr_state == RESP_ST);

  assign s_axi_awready = !aw_held;
  assign s_axi_wready  = !w_held;
  assign s_axi_bvalid  = (wr_state == RESP_ST);
  assign s_axi_bresp   = RESP;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;
  assign b_hs  = s_axi_bvalid  && s_axi_bready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_state <= IDLE;
    end else begin
      wr_state <= wr_state_nxt;
    end
  end

  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      IDLE: begin
        if (aw_hs && w_hs) begin
          wr_state_nxt = RESP_ST;
        end else if (aw_hs) begin
          wr_state_nxt = HAVE_AW;
        end else if (w_hs) begin
          wr_state_nxt = HAVE_W;
        end
      end
      HAVE_AW: begin
        if (w_hs) wr_state_nxt = RESP_ST;
      end
      HAVE_W: begin
        if (aw_hs) wr_state_nxt = RESP_ST;
      end
      RESP_ST: begin
        if (b_hs) wr_state_nxt = IDLE;
      end
      default: wr_state_nxt = IDLE;
    endcase
  end

  // Read path: a single outstanding read, arready drops while R is pending.
  assign s_axi_arready = !rvalid_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = RDATA_FILL;
  assign s_axi_rresp   = RESP;

  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs  = rvalid_q && s_axi_rready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
    end else if (r_hs) begin
      rvalid_q <= 1'b0;
    end
  end

`ifdef AXIL_ERR_RESP_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] wr_cnt, rd_cnt;

  // Counters stick at all-ones so a wrapped value never hides a burst of errors.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (b_hs && (wr_cnt != '1)) wr_cnt <= wr_cnt + CNT_ONE;
      if (r_hs && (rd_cnt != '1)) rd_cnt <= rd_cnt + CNT_ONE;
    end
  end

  assign wr_err_cnt_o = wr_cnt;
  assign rd_err_cnt_o = rd_cnt;
`else
  assign wr_err_cnt_o = '0;
  assign rd_err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axil_err_responder.sv
// Scoreboard bench for axil_err_responder: directed write/read/reset cases plus mixed traffic.
module tb_axil_err_responder;

`ifdef AXIL_ERR_RESP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, araddr, wdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [15:0] wr_cnt, rd_cnt;

  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid;
  logic        s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic [1:0]  s_wr_cnt, s_rd_cnt;

  int passed = 0;
  int total  = 0;
  int b_count = 0;
  int r_count = 0;
  int exp_wr = 0;
  int exp_rd = 0;
  logic [1:0]  q_b[$];
  logic [33:0] q_r[$];
  bit wr_done = 0;
  bit rd_done = 0;

  always #5 clk = ~clk;

  axil_err_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESP(2'b10),
    .RDATA_FILL(32'hDEAD_BEEF), .CNT_WIDTH(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .wr_err_cnt_o(wr_cnt), .rd_err_cnt_o(rd_cnt)
  );

  axil_err_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESP(2'b11), .CNT_WIDTH(2)
  ) u_sat (
    .clk_i(clk), .rst_i(rst),
    .s_axi_awaddr(32'h0), .s_axi_awprot(3'h0), .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
    .s_axi_wdata(32'h0), .s_axi_wstrb(4'h0), .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
    .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid), .s_axi_bready(1'b1),
    .s_axi_araddr(32'h0), .s_axi_arprot(3'h0), .s_axi_arvalid(1'b0), .s_axi_arready(s_arready),
    .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rvalid(s_rvalid), .s_axi_rready(1'b1),
    .wr_err_cnt_o(s_wr_cnt), .rd_err_cnt_o(s_rd_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_b();
    q_b.push_back(2'b10);
    exp_wr++;
  endtask

  task automatic push_r();
    q_r.push_back({2'b10, 32'hDEAD_BEEF});
    exp_rd++;
  endtask

  // Monitor: pops an expectation for every B/R handshake and checks valid stability.
  logic pb_v = 0, pb_r = 0, pr_v = 0, pr_r = 0;
  always @(negedge clk) begin
    if (rst) begin
      pb_v = 0; pr_v = 0;
    end else begin
      if (pb_v && !pb_r) check("bvalid_hold", bvalid, 1);
      if (pr_v && !pr_r) check("rvalid_hold", rvalid, 1);
      if (bvalid && bready) begin
        b_count++;
        check("b_expected", q_b.size() != 0, 1);
        if (q_b.size() != 0) check("bresp", bresp, q_b.pop_front());
      end
      if (rvalid && rready) begin
        r_count++;
        check("r_expected", q_r.size() != 0, 1);
        if (q_r.size() != 0) check("rresp_rdata", {rresp, rdata}, q_r.pop_front());
      end
      pb_v = bvalid; pb_r = bready; pr_v = rvalid; pr_r = rready;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b0, r0, c;
    rst = 1; awaddr = 32'h1003; araddr = 32'h2000; wdata = 32'h5555_AAAA;
    awprot = 3'h0; arprot = 3'h0; wstrb = 4'h0;
    awvalid = 0; wvalid = 0; bready = 1; arvalid = 0; rready = 1;
    s_awvalid = 0; s_wvalid = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", awready, 1);
    check("rst_wready", wready, 1);
    check("rst_arready", arready, 1);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_wr_cnt", wr_cnt, 0);
    check("rst_rd_cnt", rd_cnt, 0);
    rst = 0;
    tick();

    // AW and W together: B one cycle later, ready low during B
    awvalid = 1; wvalid = 1; push_b();
    tick();
    awvalid = 0; wvalid = 0;
    check("same_bvalid", bvalid, 1);
    check("same_bresp", bresp, 2'b10);
    check("same_awready_low", awready, 0);
    check("same_wready_low", wready, 0);
    tick();
    check("same_bvalid_clr", bvalid, 0);
    check("same_awready_back", awready, 1);
    check("same_wready_back", wready, 1);

    // AW at cycle 0, W at cycle 3
    awvalid = 1;
    tick();
    awvalid = 0;
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) begin wvalid = 1; push_b(); end
      check("split_awready", awready, 0);
      check("split_wready", wready, 1);
      check("split_bvalid_early", bvalid, 0);
      tick();
    end
    wvalid = 0;
    check("split_bvalid", bvalid, 1);
    tick();
    check("split_bvalid_clr", bvalid, 0);

    // Read held off by rready low for 5 cycles
    rready = 0; arvalid = 1; push_r();
    check("ar_arready", arready, 1);
    tick();
    arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      check("stall_rvalid", rvalid, 1);
      check("stall_rdata", rdata, 32'hDEAD_BEEF);
      check("stall_arready", arready, 0);
      tick();
    end
    rready = 1;
    tick();
    check("stall_rvalid_clr", rvalid, 0);
    check("stall_arready_back", arready, 1);
    check("cnt_wr_pre", wr_cnt, CNT_EN ? 16'(exp_wr) : 16'd0);
    check("cnt_rd_pre", rd_cnt, CNT_EN ? 16'(exp_rd) : 16'd0);

    // Reset while in HAVE_AW: dropped without a response
    awvalid = 1;
    tick();
    awvalid = 0;
    check("haveaw_awready", awready, 0);
    rst = 1;
    #1;
    check("arst_awready", awready, 1);
    check("arst_wready", wready, 1);
    check("arst_bvalid", bvalid, 0);
    check("arst_wr_cnt", wr_cnt, 0);
    tick();
    rst = 0; exp_wr = 0; exp_rd = 0;
    tick();
    b0 = b_count;
    awvalid = 1; wvalid = 1; push_b();
    tick();
    awvalid = 0; wvalid = 0;
    check("post_rst_bvalid", bvalid, 1);
    repeat (3) tick();
    check("post_rst_one_b", b_count - b0, 1);

    // Concurrent traffic with random ready stalls
    b0 = b_count; r0 = r_count;
    fork
      begin
        for (int wi = 0; wi < 10; wi++) begin
          int da, dw, wc;
          logic awp, wp, aw_hs, w_hs;
          awp = 1; wp = 1; wc = 0;
          da = (wi % 2 == 1) ? (wi % 3) : 0;
          dw = (wi % 2 == 0) ? (wi % 3) : 0;
          while ((awp || wp) && wc < 200) begin
            awvalid = awp && (wc >= da);
            wvalid  = wp && (wc >= dw);
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) awp = 0;
            if (w_hs) wp = 0;
            wc++;
          end
          awvalid = 0; wvalid = 0;
          check("wr_drv_timeout", awp || wp, 0);
          if (!awp && !wp) push_b();
        end
        wr_done = 1;
      end
      begin
        for (int ri = 0; ri < 10; ri++) begin
          int rc;
          logic arp, ar_hs;
          arp = 1; rc = 0;
          while (arp && rc < 200) begin
            arvalid = (rc >= (ri % 2));
            @(negedge clk);
            ar_hs = arvalid && arready;
            tick();
            if (ar_hs) begin arp = 0; push_r(); end
            rc++;
          end
          arvalid = 0;
          check("rd_drv_timeout", arp, 0);
        end
        rd_done = 1;
      end
      begin
        int cyc;
        cyc = 0;
        while (!(wr_done && rd_done) && cyc < 4000) begin
          bready = 1'($urandom_range(0, 1));
          rready = 1'($urandom_range(0, 1));
          tick();
          cyc++;
        end
        bready = 1; rready = 1;
      end
    join
    c = 0;
    while ((q_b.size() != 0 || q_r.size() != 0) && c < 100) begin
      tick();
      c++;
    end
    check("drain_b", q_b.size(), 0);
    check("drain_r", q_r.size(), 0);
    check("traffic_b_count", b_count - b0, 10);
    check("traffic_r_count", r_count - r0, 10);
    check("cnt_wr_final", wr_cnt, CNT_EN ? 16'd11 : 16'd0);
    check("cnt_rd_final", rd_cnt, CNT_EN ? 16'd10 : 16'd0);

    // Saturation on a 2-bit counter instance
    for (int si = 0; si < 5; si++) begin
      s_awvalid = 1; s_wvalid = 1;
      tick();
      s_awvalid = 0; s_wvalid = 0;
      check("sat_bresp", s_bresp, 2'b11);
      check("sat_bvalid", s_bvalid, 1);
      tick();
    end
    check("sat_wr_cnt", s_wr_cnt, CNT_EN ? 2'b11 : 2'b00);
    check("sat_rd_cnt", s_rd_cnt, 2'b00);
    check("sat_read_idle", {s_arready, s_rvalid, s_rresp, s_rdata}, {1'b1, 1'b0, 2'b11, 32'h0});
    check("sat_ready_idle", {s_awready, s_wready}, 2'b11);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
